// File: rtl/clock_monitor.sv
// Measures high/low phase lengths of an asynchronous mon_clk in clk cycles, flags
// out-of-tolerance phases and stalls, and reports lock after LOCK_CNT good periods.
module clock_monitor #(
  parameter int CNT_W    = 16,
  parameter int EXP_HALF = 8,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mon_clk,
  input  logic             clear,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             meas_valid,
  output logic             err_high,
  output logic             err_low,
  output logic             err_stall,
  output logic             locked,
  output logic [15:0]      good_periods
);

  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW, STALL} state_t;

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W:0]   LEN_MIN = (CNT_W+1)'(EXP_HALF - TOL);
  localparam logic [CNT_W:0]   LEN_MAX = (CNT_W+1)'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CW-1:0]    LOCK_N  = CW'(LOCK_CNT);

  state_t           state, state_nx;
  logic             s1, s2, s3;
  logic             rise, fall, any_edge;
  logic [CNT_W-1:0] cnt;
  logic [CW-1:0]    consec;
  logic             high_ok;
  logic             chk_high, chk_low, go_stall, len_good;

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign any_edge = rise | fall;
  // Widened compare so bounds near the counter limit cannot wrap.
  assign len_good = ({1'b0, cnt} >= LEN_MIN) && ({1'b0, cnt} <= LEN_MAX);

  always_comb begin
    state_nx = state;
    chk_high = 1'b0;
    chk_low  = 1'b0;
    go_stall = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nx = MEAS_HIGH;
      end
      MEAS_HIGH: begin
        if (fall) begin
          chk_high = 1'b1;
          state_nx = MEAS_LOW;
        end else if (!any_edge && cnt == TMO) begin
          go_stall = 1'b1;
          state_nx = STALL;
        end
      end
      MEAS_LOW: begin
        if (rise) begin
          chk_low  = 1'b1;
          state_nx = MEAS_HIGH;
        end else if (!any_edge && cnt == TMO) begin
          go_stall = 1'b1;
          state_nx = STALL;
        end
      end
      STALL: begin
        if (rise)      state_nx = MEAS_HIGH;
        else if (fall) state_nx = MEAS_LOW;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      cnt          <= '0;
      consec       <= '0;
      high_ok      <= 1'b0;
      high_len     <= '0;
      low_len      <= '0;
      meas_valid   <= 1'b0;
      err_high     <= 1'b0;
      err_low      <= 1'b0;
      err_stall    <= 1'b0;
      locked       <= 1'b0;
      good_periods <= '0;
    end else begin
      s1    <= mon_clk;
      s2    <= s1;
      s3    <= s2;
      state <= state_nx;

      if (any_edge)       cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (cnt != '1) cnt <= cnt + 1'b1;

      meas_valid <= chk_high | chk_low;
      if (chk_high) high_len <= cnt;
      if (chk_low)  low_len  <= cnt;

      // A flag set in the same cycle as clear survives.
      err_high  <= (err_high  & ~clear) | (chk_high & ~len_good);
      err_low   <= (err_low   & ~clear) | (chk_low  & ~len_good);
      err_stall <= (err_stall & ~clear) | go_stall;

      if (chk_high)                 high_ok <= len_good;
      else if (chk_low || go_stall) high_ok <= 1'b0;

      if (go_stall || ((chk_high || chk_low) && !len_good)) begin
        consec <= '0;
        locked <= 1'b0;
      end else if (chk_low && high_ok) begin
        if (consec < LOCK_N)            consec <= consec + 1'b1;
        if (consec >= LOCK_N - 1'b1)    locked <= 1'b1;
        if (good_periods != 16'hFFFF)   good_periods <= good_periods + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: phase-pattern table plus stall, clear-race and reset sequences.
module tb_clock_monitor;

  logic        clk = 1'b0;
  logic        reset, mon_clk, clear;
  logic [15:0] high_len, low_len, good_periods;
  logic        meas_valid, err_high, err_low, err_stall, locked;

  clock_monitor dut (
    .clk(clk), .reset(reset), .mon_clk(mon_clk), .clear(clear),
    .high_len(high_len), .low_len(low_len), .meas_valid(meas_valid),
    .err_high(err_high), .err_low(err_low), .err_stall(err_stall),
    .locked(locked), .good_periods(good_periods)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lo; int hi; int n; bit clr;
    int hl; int ll; bit eh; bit el; bit lk; int gp; int mv;
  } vec_t;

  vec_t vt[14];
  int   total = 0;
  int   bad   = 0;
  int   mv_cnt = 0;
  int   b2b    = 0;
  logic mv_prev = 1'b0;
  int   base;

  always @(negedge clk) begin
    if (meas_valid === 1'b1) mv_cnt++;
    if (meas_valid === 1'b1 && mv_prev === 1'b1) b2b++;
    mv_prev = meas_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Each period is a low phase followed by a high phase.
  task automatic run(input int lo, input int hi, input int n, input bit clr);
    for (int p = 0; p < n; p++) begin
      mon_clk = 1'b0;
      for (int c = 0; c < lo; c++) begin
        if (p == 0 && c == 0) clear = clr;
        tick();
        clear = 1'b0;
      end
      mon_clk = 1'b1;
      repeat (hi) tick();
    end
  endtask

  initial begin
    //            lo hi  n clr   hl  ll eh el lk  gp  mv
    vt[0]  = '{8,  8, 4, 0,    8,  8, 0, 0, 0,  3,  6};
    vt[1]  = '{8,  8, 1, 0,    8,  8, 0, 0, 1,  4,  8};
    vt[2]  = '{8, 10, 1, 0,    8,  8, 0, 0, 1,  5, 10};
    vt[3]  = '{8,  8, 1, 0,   10,  8, 1, 0, 0,  5, 12};
    vt[4]  = '{8,  8, 3, 0,    8,  8, 1, 0, 0,  8, 18};
    vt[5]  = '{8,  8, 1, 1,    8,  8, 0, 0, 1,  9, 20};
    vt[6]  = '{9,  7, 1, 0,    8,  9, 0, 0, 1, 10, 22};
    vt[7]  = '{9,  7, 1, 0,    7,  9, 0, 0, 1, 11, 24};
    vt[8]  = '{6,  8, 1, 0,    7,  6, 0, 1, 0, 11, 26};
    vt[9]  = '{9,  7, 3, 0,    7,  9, 0, 1, 0, 14, 32};
    vt[10] = '{9,  7, 1, 0,    7,  9, 0, 1, 1, 15, 34};
    vt[11] = '{7,  9, 1, 0,    7,  7, 0, 1, 1, 16, 36};
    vt[12] = '{8,  6, 1, 0,    9,  8, 0, 1, 1, 17, 38};
    vt[13] = '{8,  8, 1, 0,    6,  8, 1, 1, 0, 17, 40};

    reset = 1'b1; mon_clk = 1'b0; clear = 1'b0;
    repeat (3) tick();
    chk("rst high_len", int'(high_len), 0);
    chk("rst low_len", int'(low_len), 0);
    chk("rst meas_valid", int'(meas_valid), 0);
    chk("rst err_high", int'(err_high), 0);
    chk("rst err_low", int'(err_low), 0);
    chk("rst err_stall", int'(err_stall), 0);
    chk("rst locked", int'(locked), 0);
    chk("rst good_periods", int'(good_periods), 0);
    reset = 1'b0;
    base = mv_cnt;

    for (int i = 0; i < 14; i++) begin
      run(vt[i].lo, vt[i].hi, vt[i].n, vt[i].clr);
      chk($sformatf("v%0d high_len", i), int'(high_len), vt[i].hl);
      chk($sformatf("v%0d low_len", i), int'(low_len), vt[i].ll);
      chk($sformatf("v%0d err_high", i), int'(err_high), int'(vt[i].eh));
      chk($sformatf("v%0d err_low", i), int'(err_low), int'(vt[i].el));
      chk($sformatf("v%0d err_stall", i), int'(err_stall), 0);
      chk($sformatf("v%0d locked", i), int'(locked), int'(vt[i].lk));
      chk($sformatf("v%0d good_periods", i), int'(good_periods), vt[i].gp);
      chk($sformatf("v%0d meas_count", i), mv_cnt - base, vt[i].mv);
    end

    // Stall: lock, hold mon_clk low, err_stall exactly 64 cycles after the detected fall.
    reset = 1'b1; mon_clk = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    run(8, 8, 5, 1'b0);
    chk("stall pre locked", int'(locked), 1);
    chk("stall pre good_periods", int'(good_periods), 4);
    mon_clk = 1'b0;
    repeat (66) tick();
    chk("stall t-1 err_stall", int'(err_stall), 0);
    chk("stall t-1 locked", int'(locked), 1);
    tick();
    chk("stall err_stall", int'(err_stall), 1);
    chk("stall locked", int'(locked), 0);
    chk("stall err_high", int'(err_high), 0);
    base = mv_cnt;
    run(8, 8, 4, 1'b0);
    chk("resume meas_count", mv_cnt - base, 6);
    chk("resume locked early", int'(locked), 0);
    chk("resume err_stall sticky", int'(err_stall), 1);
    run(8, 8, 1, 1'b0);
    chk("resume locked", int'(locked), 1);
    chk("resume good_periods", int'(good_periods), 8);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear err_stall", int'(err_stall), 0);

    // Clear in the same cycle a bad 12-cycle high phase is checked.
    mon_clk = 1'b0; repeat (8) tick();
    mon_clk = 1'b1; repeat (12) tick();
    mon_clk = 1'b0; tick(); tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("race meas_valid", int'(meas_valid), 1);
    chk("race high_len", int'(high_len), 12);
    chk("race err_high", int'(err_high), 1);
    chk("race locked", int'(locked), 0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("race cleared err_high", int'(err_high), 0);

    // Reset in the middle of a high phase.
    mon_clk = 1'b0; repeat (6) tick();
    mon_clk = 1'b1; repeat (4) tick();
    reset = 1'b1; tick();
    chk("midrst high_len", int'(high_len), 0);
    chk("midrst low_len", int'(low_len), 0);
    chk("midrst meas_valid", int'(meas_valid), 0);
    chk("midrst locked", int'(locked), 0);
    chk("midrst good_periods", int'(good_periods), 0);
    chk("midrst errs", int'({err_high, err_low, err_stall}), 0);
    mon_clk = 1'b0; repeat (2) tick();
    reset = 1'b0;
    base = mv_cnt;
    repeat (8) tick();
    mon_clk = 1'b1; repeat (8) tick();
    chk("midrst first rise no meas", mv_cnt - base, 0);
    mon_clk = 1'b0; tick(); tick();
    chk("midrst pre fall meas_valid", int'(meas_valid), 0);
    tick();
    chk("midrst fall meas_valid", int'(meas_valid), 1);
    chk("midrst fall high_len", int'(high_len), 8);
    chk("midrst fall low_len", int'(low_len), 0);
    chk("midrst fall meas_count", mv_cnt - base, 0);
    tick();

    chk("meas_valid back-to-back", b2b, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
# clock_monitor

Synthesizable checker for a free-running monitored clock, the receiving end of the clock generator model. Samples `mon_clk` with the system clock and measures every high and low phase in system-clock cycles. Checks each phase against an expected half-period with tolerance, detects a stopped clock, and reports lock once the monitored clock has been stable for a set number of periods. Sits in the testbench/bring-up path beside the clock source it supervises.

## Interface

Parameters:
- `CNT_W`, 16, width of phase counter and length outputs.
- `EXP_HALF`, 8, expected half-period in `clk` cycles.
- `TOL`, 1, allowed absolute deviation from `EXP_HALF`; must be less than `EXP_HALF`.
- `LOCK_CNT`, 4, consecutive good full periods required for lock.
- `TIMEOUT`, 64, phase length that triggers a stall; must be greater than `EXP_HALF+TOL` and less than 2^CNT_W.

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: synchronous reset, active-high.
- `mon_clk` in 1: monitored clock, asynchronous to `clk`.
- `clear` in 1: clears the sticky error flags.
- `high_len` out CNT_W: last measured high-phase length.
- `low_len` out CNT_W: last measured low-phase length.
- `meas_valid` out 1: one-cycle pulse when `high_len` or `low_len` updates.
- `err_high` out 1: sticky flag, high phase out of tolerance.
- `err_low` out 1: sticky flag, low phase out of tolerance.
- `err_stall` out 1: sticky flag, no edge within `TIMEOUT`.
- `locked` out 1: monitored clock stable.
- `good_periods` out 16: count of good full periods, saturating at 0xFFFF.

## Operation

- **Synchronizer and edge detect:** two flops (`s1`, `s2`) plus a history flop (`s3`).
  - `rise` = `s2 & ~s3`; `fall` = `~s2 & s3`.
- **Phase counter `cnt`:**
  - Loads 1 on any edge cycle.
  - Otherwise increments, saturating at all-ones.
  - Measured length on an edge = `cnt` before the load, i.e. the number of `clk` cycles between the two detected edges.
- **FSM states:** IDLE, MEAS_HIGH, MEAS_LOW, STALL.
  - IDLE: ignore `fall`. On `rise`, go to MEAS_HIGH with no measurement. No timeout in IDLE.
  - MEAS_HIGH:
    - On `fall`, write `high_len`, pulse `meas_valid`, check, then go to MEAS_LOW.
    - On `cnt == TIMEOUT` with no edge, go to STALL.
  - MEAS_LOW:
    - On `rise`, write `low_len`, pulse `meas_valid`, check, then go to MEAS_HIGH. This rise completes a full period.
    - On `cnt == TIMEOUT` with no edge, go to STALL.
  - STALL: on the first edge, go to MEAS_HIGH (on `rise`) or MEAS_LOW (on `fall`). No measurement on that edge.
- **Check:** a phase is good iff `EXP_HALF-TOL <= len <= EXP_HALF+TOL`. Compare at CNT_W+1 bits, with no wrap.
  - Bad high phase sets `err_high`; bad low phase sets `err_low`.
- **Lock:**
  - An internal counter `consec` counts full periods in which both phases were good.
  - `locked` sets when `consec` reaches `LOCK_CNT`; `consec` saturates at `LOCK_CNT`.
  - Any bad phase or stall clears `consec` and `locked` in the same update.
  - `good_periods` increments on each good full period and is never cleared except by `reset`.
- **Stall:** on entering STALL, set `err_stall` and clear `locked` and `consec`.
- **`clear`:** zeroes the three error flags. A flag set in the same cycle wins, so it reads 1 afterwards.
- **Reset:** state IDLE. All outputs, `cnt`, `consec` and the sync flops go to 0. A reset mid-phase discards that phase.

## Timing

- `mon_clk` change first sampled at clk edge k:
  - `s2` changes at edge k+1.
  - Edge is detected during cycle k+1..k+2.
  - `high_len`/`low_len`, `meas_valid`, error flags and `locked` update at edge k+2.
- Added latency is constant, so measured lengths equal the true period ±1 for asynchronous sources. Lengths are exact when `mon_clk` is derived from `clk`.
- `err_stall` asserts at the edge where `cnt` would step from `TIMEOUT` (i.e. `TIMEOUT` cycles after the last detected edge).
- `meas_valid` is never high in two consecutive cycles, provided `mon_clk` phases last at least 2 `clk` cycles. Shorter phases are out of scope and may be missed.
- Flag and lock updates from one check are visible in the same cycle as the associated `meas_valid`.

## Test plan

All scenarios use default parameters.
1. `mon_clk` toggles every 8 `clk` cycles after reset.
   - `meas_valid` pulses per edge after the first rise; `high_len = low_len = 8`.
   - `locked` = 1 on the 4th completed period; no error flags; `good_periods` counts 1, 2, 3…
2. High 10 / low 8 after lock.
   - `high_len = 10`, `err_high` = 1 on the fall.
   - `locked` = 0 on the same update and relocks only after 4 later good periods.
3. High 7 / low 9.
   - No errors; lock acquired after 4 periods (tolerance boundary).
4. After lock, `mon_clk` held low.
   - `err_stall` = 1 and `locked` = 0 exactly 64 cycles after the fall.
   - Toggling resumes: no measurement on the first edge, relock after 4 good periods.
   - `clear` pulse then drops `err_stall`.
5. Assert `clear` in the cycle a high phase of 12 is checked.
   - `err_high` reads 1 afterwards.
6. `reset` mid high phase.
   - All outputs 0 next cycle, state IDLE.
   - A low phase followed by a rise produces no `meas_valid`; the first `meas_valid` is on the following fall.
